// File: rtl/lockout_sequencer_if.sv
// lockout_sequencer_if: bundles the code-entry pulses and lockout status of lockout_sequencer
//   master: drives attempt_ok, attempt_fail, relock, admin_clr; observes the status outputs
//   slave : the sequencer itself; samples the pulses, drives gen_stop, unlocked,
//           error_counter[2:0], lock_remain[7:0], lock_level[1:0]
interface lockout_sequencer_if;
   logic       attempt_ok;
   logic       attempt_fail;
   logic       relock;
   logic       admin_clr;
   logic       gen_stop;
   logic       unlocked;
   logic [2:0] error_counter;
   logic [7:0] lock_remain;
   logic [1:0] lock_level;
   modport master (
      output attempt_ok, attempt_fail, relock, admin_clr,
      input  gen_stop, unlocked, error_counter, lock_remain, lock_level
   );
   modport slave (
      input  attempt_ok, attempt_fail, relock, admin_clr,
      output gen_stop, unlocked, error_counter, lock_remain, lock_level
   );
endinterface

// File: rtl/lockout_sequencer.sv
// lockout_sequencer: code-entry lockout FSM (ACCEPT / LOCKOUT / UNLOCKED) with tick-timed lockout
//   clk, rst : single clock, synchronous active-high reset
//   bus      : lockout_sequencer_if.slave (attempt pulses in, lockout status out)
//   LOCKOUT_ESCALATE_EN : when defined, lockout duration doubles per lock_level (saturating at 255)
module lockout_sequencer #(
   parameter int MAX_FAIL  = 3,
   parameter int LOCK_SECS = 30,
   parameter int TICK_DIV  = 100000000
) (
   input logic                clk,
   input logic                rst,
   lockout_sequencer_if.slave bus
);
   localparam logic [1:0] ACCEPT   = 2'd0;
   localparam logic [1:0] LOCKOUT  = 2'd1;
   localparam logic [1:0] UNLOCKED = 2'd2;
   localparam int PW = $clog2(TICK_DIV);
   logic [1:0]    st, st_n, lvl;
   logic [2:0]    err, err_n;
   logic [7:0]    rem, rem_n, dur;
   logic [PW-1:0] pre, pre_n;
   logic          gen_stop_q, unlocked_q;
   logic          fail_go, ok_go, tick, lock_exit, at_limit;
   // a simultaneous fail masks the ok pulse
   assign fail_go   = st == ACCEPT && bus.attempt_fail;
   assign ok_go     = st == ACCEPT && !bus.attempt_fail && bus.attempt_ok;
   assign tick      = st == LOCKOUT && pre == PW'(TICK_DIV - 1);
   assign lock_exit = tick && rem == 8'd1;
   assign at_limit  = {1'b0, err} + 4'd1 >= 4'(MAX_FAIL);
`ifdef LOCKOUT_ESCALATE_EN
   logic [1:0]  lvl_n;
   logic [10:0] dur_w;
   assign dur_w = 11'(LOCK_SECS) << lvl;
   assign dur   = |dur_w[10:8] ? 8'hFF : dur_w[7:0];
   assign lvl_n = bus.admin_clr || ok_go ? 2'd0 : lock_exit && lvl != 2'd3 ? lvl + 2'd1 : lvl;
   always_ff @(posedge clk) lvl <= rst ? 2'd0 : lvl_n;
`else
   assign dur = 8'(LOCK_SECS);
   assign lvl = 2'd0;
`endif
   always_comb begin
      st_n  = st;
      err_n = err;
      rem_n = rem;
      pre_n = pre;
      if (bus.admin_clr) begin
         st_n  = ACCEPT;
         err_n = '0;
         rem_n = '0;
         pre_n = '0;
      end else if (fail_go) begin
         err_n = err == 3'd7 ? err : err + 3'd1;
         if (at_limit) begin
            st_n  = LOCKOUT;
            rem_n = dur;
            pre_n = '0;
         end
      end else if (ok_go) begin
         st_n  = UNLOCKED;
         err_n = '0;
      end else if (st == LOCKOUT) begin
         pre_n = tick ? '0 : pre + 1'b1;
         rem_n = tick ? rem - 8'd1 : rem;
         // leave one failure of headroom so the next miss re-locks immediately
         if (lock_exit) begin
            st_n  = ACCEPT;
            err_n = 3'(MAX_FAIL - 1);
         end
      end else if (st == UNLOCKED && bus.relock) begin
         st_n = ACCEPT;
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         st         <= ACCEPT;
         err        <= '0;
         rem        <= '0;
         pre        <= '0;
         gen_stop_q <= 1'b0;
         unlocked_q <= 1'b0;
      end else begin
         st         <= st_n;
         err        <= err_n;
         rem        <= rem_n;
         pre        <= pre_n;
         gen_stop_q <= st_n == LOCKOUT;
         unlocked_q <= st_n == UNLOCKED;
      end
   end
   assign bus.gen_stop      = gen_stop_q;
   assign bus.unlocked      = unlocked_q;
   assign bus.error_counter = err;
   assign bus.lock_remain   = rem;
   assign bus.lock_level    = lvl;
endmodule

// File: tb/tb_lockout_sequencer.sv
// tb_lockout_sequencer: scoreboard bench for lockout_sequencer (MAX_FAIL=3, LOCK_SECS=3, TICK_DIV=4)
module tb_lockout_sequencer;
`ifdef LOCKOUT_ESCALATE_EN
   localparam bit ESC = 1'b1;
`else
   localparam bit ESC = 1'b0;
`endif
   localparam logic [1:0] L1 = ESC ? 2'd1 : 2'd0;
   localparam logic [1:0] L2 = ESC ? 2'd2 : 2'd0;
   localparam int D2 = ESC ? 6 : 3;
   typedef struct {
      bit         chk;
      string      nm;
      bit         gs;
      bit         un;
      logic [2:0] ec;
      logic [7:0] lr;
      logic [1:0] ll;
   } exp_t;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_chk = 0;
   int   n_pass = 0;
   exp_t q[$];
   exp_t e;
   lockout_sequencer_if bus();
   lockout_sequencer #(.MAX_FAIL(3), .LOCK_SECS(3), .TICK_DIV(4)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );
   always #5 clk = ~clk;
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (q.size() != 0) begin
            e = q.pop_front();
            if (e.chk) begin
               n_chk++;
               if ({bus.gen_stop, bus.unlocked, bus.error_counter, bus.lock_remain, bus.lock_level} ===
                   {e.gs, e.un, e.ec, e.lr, e.ll})
                  n_pass++;
               else
                  $display("FAIL %s: got gs=%0b un=%0b ec=%0d lr=%0d ll=%0d, want gs=%0b un=%0b ec=%0d lr=%0d ll=%0d",
                           e.nm, bus.gen_stop, bus.unlocked, bus.error_counter, bus.lock_remain,
                           bus.lock_level, e.gs, e.un, e.ec, e.lr, e.ll);
            end
         end
      end
   end
   task automatic step(input bit r, ok, fl, rl, cl, chk, gs, un, input logic [2:0] ec,
                       input logic [7:0] lr, input logic [1:0] ll, input string nm);
      @(negedge clk);
      rst              = r;
      bus.attempt_ok   = ok;
      bus.attempt_fail = fl;
      bus.relock       = rl;
      bus.admin_clr    = cl;
      q.push_back('{chk, nm, gs, un, ec, lr, ll});
   endtask
   task automatic lock_run(input int d, input logic [1:0] ll_in, ll_out, input int ok_at);
      for (int k = 1; k <= d * 4; k++) begin
         bit last;
         last = k == d * 4;
         step(0, k == ok_at, 0, 0, 0, 1, !last, 0, last ? 3'd2 : 3'd3, 8'(d - k / 4),
              last ? ll_out : ll_in, $sformatf("lockout d=%0d k=%0d", d, k));
      end
   endtask
   task automatic lock_partial();
      for (int k = 1; k <= 4; k++)
         step(0, 0, 0, 0, 0, 1, 1, 0, 3'd3, 8'(3 - k / 4), 2'd0, $sformatf("partial k=%0d", k));
   endtask
   initial begin
      bus.attempt_ok = 0;
      bus.attempt_fail = 0;
      bus.relock = 0;
      bus.admin_clr = 0;
      step(1, 0, 0, 0, 0, 0, 0, 0, 3'd0, 8'd0, 2'd0, "rst0");
      step(1, 1, 1, 1, 1, 1, 0, 0, 3'd0, 8'd0, 2'd0, "reset");
      step(0, 0, 1, 0, 0, 1, 0, 0, 3'd1, 8'd0, 2'd0, "fail1");
      step(0, 0, 1, 0, 0, 1, 0, 0, 3'd2, 8'd0, 2'd0, "fail2");
      step(0, 0, 1, 0, 0, 1, 1, 0, 3'd3, 8'd3, 2'd0, "fail3 lock");
      lock_run(3, 2'd0, L1, 2);
      step(0, 0, 1, 0, 0, 1, 1, 0, 3'd3, 8'(D2), L1, "relock fail");
      lock_run(D2, L1, L2, 5);
      step(0, 0, 0, 0, 1, 1, 0, 0, 3'd0, 8'd0, 2'd0, "admin clr");
      step(0, 0, 0, 1, 0, 1, 0, 0, 3'd0, 8'd0, 2'd0, "relock in accept");
      step(0, 1, 1, 0, 0, 1, 0, 0, 3'd1, 8'd0, 2'd0, "ok+fail");
      step(0, 1, 0, 0, 0, 1, 0, 1, 3'd0, 8'd0, 2'd0, "ok unlock");
      step(0, 0, 1, 0, 0, 1, 0, 1, 3'd0, 8'd0, 2'd0, "fail in unlocked");
      step(0, 0, 0, 1, 0, 1, 0, 0, 3'd0, 8'd0, 2'd0, "relock");
      step(0, 0, 1, 0, 0, 1, 0, 0, 3'd1, 8'd0, 2'd0, "p fail1");
      step(0, 0, 1, 0, 0, 1, 0, 0, 3'd2, 8'd0, 2'd0, "p fail2");
      step(0, 0, 1, 0, 0, 1, 1, 0, 3'd3, 8'd3, 2'd0, "p fail3");
      lock_partial();
      step(0, 0, 0, 0, 1, 1, 0, 0, 3'd0, 8'd0, 2'd0, "clr mid lock");
      step(0, 0, 1, 0, 0, 1, 0, 0, 3'd1, 8'd0, 2'd0, "q fail1");
      step(0, 0, 1, 0, 0, 1, 0, 0, 3'd2, 8'd0, 2'd0, "q fail2");
      step(0, 0, 1, 0, 0, 1, 1, 0, 3'd3, 8'd3, 2'd0, "q fail3");
      lock_partial();
      step(1, 0, 0, 0, 1, 1, 0, 0, 3'd0, 8'd0, 2'd0, "rst mid lock");
      step(0, 0, 1, 0, 0, 1, 0, 0, 3'd1, 8'd0, 2'd0, "fail after rst");
      step(0, 0, 1, 0, 1, 1, 0, 0, 3'd0, 8'd0, 2'd0, "clr beats fail");
      step(0, 0, 0, 0, 0, 0, 0, 0, 3'd0, 8'd0, 2'd0, "idle");
      for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clk);
      #2;
      n_chk++;
      if (q.size() == 0) n_pass++;
      else $display("FAIL drain: got %0d pending, want 0", q.size());
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
